// File: rtl/alu_packet_engine_if.sv
// Byte-stream bus for alu_packet_engine: inbound (s_axis) and outbound (m_axis) handshakes.
// The engine connects through the slave modport; the traffic source/sink uses master.
interface alu_packet_engine_if;
  logic [7:0] s_axis_tdata_i;
  logic       s_axis_tvalid_i;
  logic       s_axis_tready_o;
  logic [7:0] m_axis_tdata_o;
  logic       m_axis_tvalid_o;
  logic       m_axis_tready_i;

  modport slave (
    input  s_axis_tdata_i,
    input  s_axis_tvalid_i,
    output s_axis_tready_o,
    output m_axis_tdata_o,
    output m_axis_tvalid_o,
    input  m_axis_tready_i
  );

  modport master (
    output s_axis_tdata_i,
    output s_axis_tvalid_i,
    input  s_axis_tready_o,
    input  m_axis_tdata_o,
    input  m_axis_tvalid_o,
    output m_axis_tready_i
  );
endinterface

// File: rtl/alu_packet_engine.sv
// Packet engine: parses opcode/reserved/length header, then echoes or sums the payload.
// Define ALU_PKT_SUB_EN to enable opcode 0x02 (first operand minus all later operands).
module alu_packet_engine #(
  parameter int OPERAND_WIDTH = 32,
  parameter int MAX_PAYLOAD   = 1024
) (
  input  logic               clk_i,
  input  logic               reset_i,
  alu_packet_engine_if.slave bus,
  output logic               busy_o,
  output logic               err_o
);
  localparam int NBYTES = OPERAND_WIDTH / 8;
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'h01;
`ifdef ALU_PKT_SUB_EN
  localparam logic [7:0] OP_SUB  = 8'h02;
`endif

  typedef enum logic [2:0] {IDLE, RSVD, LEN_LO, LEN_HI, ECHO, ACCUM, RESULT, DRAIN} state_t;
  state_t state, state_next;

  logic [7:0]               opcode, len_lo, echo_data;
  logic                     echo_valid, err_q;
  logic [15:0]              remaining, length, payload;
  logic [OPERAND_WIDTH-1:0] acc, op_buf, res_shift, new_op, acc_next;
  logic [3:0]               byte_pos, res_cnt;
  logic                     in_fire, out_fire, len_bad, op_known, op_done;
`ifdef ALU_PKT_SUB_EN
  logic                     first_op, is_sub;
`endif

  assign in_fire  = bus.s_axis_tvalid_i && bus.s_axis_tready_o;
  assign out_fire = bus.m_axis_tvalid_o && bus.m_axis_tready_i;
  assign busy_o   = (state != IDLE);
  assign err_o    = err_q;

  // Header decode and operand assembly; a trailing partial operand closes on the last payload byte.
  always_comb begin
    length   = {bus.s_axis_tdata_i, len_lo};
    payload  = length - 16'd4;
    len_bad  = (length < 16'd4) || (32'(payload) > $unsigned(MAX_PAYLOAD));
`ifdef ALU_PKT_SUB_EN
    op_known = (opcode == OP_ECHO) || (opcode == OP_ADD) || (opcode == OP_SUB);
`else
    op_known = (opcode == OP_ECHO) || (opcode == OP_ADD);
`endif
    new_op   = op_buf | (OPERAND_WIDTH'(bus.s_axis_tdata_i) << {byte_pos, 3'b000});
    op_done  = (byte_pos == 4'(NBYTES - 1)) || (remaining == 16'd1);
`ifdef ALU_PKT_SUB_EN
    if (first_op)    acc_next = new_op;
    else if (is_sub) acc_next = acc - new_op;
    else             acc_next = acc + new_op;
`else
    acc_next = acc + new_op;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next          = state;
    bus.s_axis_tready_o = 1'b0;
    bus.m_axis_tvalid_o = 1'b0;
    bus.m_axis_tdata_o  = echo_data;
    case (state)
      IDLE: begin
        bus.s_axis_tready_o = 1'b1;
        if (bus.s_axis_tvalid_i) state_next = RSVD;
      end
      RSVD: begin
        bus.s_axis_tready_o = 1'b1;
        if (bus.s_axis_tvalid_i) state_next = LEN_LO;
      end
      LEN_LO: begin
        bus.s_axis_tready_o = 1'b1;
        if (bus.s_axis_tvalid_i) state_next = LEN_HI;
      end
      LEN_HI: begin
        bus.s_axis_tready_o = 1'b1;
        if (bus.s_axis_tvalid_i) begin
          if (len_bad)               state_next = IDLE;
          else if (!op_known)        state_next = (payload == 16'd0) ? IDLE : DRAIN;
          else if (opcode == OP_ECHO) state_next = (payload == 16'd0) ? IDLE : ECHO;
          else                       state_next = (payload == 16'd0) ? RESULT : ACCUM;
        end
      end
      // Stay here after the last byte is taken until the output register has emptied.
      ECHO: begin
        bus.s_axis_tready_o = (remaining != 16'd0) && (!echo_valid || bus.m_axis_tready_i);
        bus.m_axis_tvalid_o = echo_valid;
        if (remaining == 16'd0 && (!echo_valid || bus.m_axis_tready_i)) state_next = IDLE;
      end
      ACCUM: begin
        bus.s_axis_tready_o = 1'b1;
        if (bus.s_axis_tvalid_i && remaining == 16'd1) state_next = RESULT;
      end
      RESULT: begin
        bus.m_axis_tvalid_o = 1'b1;
        bus.m_axis_tdata_o  = res_shift[7:0];
        if (bus.m_axis_tready_i && res_cnt == 4'd1) state_next = IDLE;
      end
      DRAIN: begin
        bus.s_axis_tready_o = 1'b1;
        if (bus.s_axis_tvalid_i && remaining == 16'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset_i) bus.s_axis_tready_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      opcode     <= '0;
      len_lo     <= '0;
      echo_data  <= '0;
      echo_valid <= 1'b0;
      err_q      <= 1'b0;
      remaining  <= '0;
      acc        <= '0;
      op_buf     <= '0;
      res_shift  <= '0;
      byte_pos   <= '0;
      res_cnt    <= '0;
`ifdef ALU_PKT_SUB_EN
      first_op   <= 1'b0;
      is_sub     <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: if (in_fire) begin
          opcode   <= bus.s_axis_tdata_i;
          acc      <= '0;
          op_buf   <= '0;
          byte_pos <= '0;
`ifdef ALU_PKT_SUB_EN
          first_op <= 1'b1;
          is_sub   <= (bus.s_axis_tdata_i == OP_SUB);
`endif
        end
        LEN_LO: if (in_fire) len_lo <= bus.s_axis_tdata_i;
        LEN_HI: if (in_fire) begin
          remaining <= payload;
          res_cnt   <= 4'(NBYTES);
          res_shift <= '0;
          err_q     <= len_bad || !op_known;
        end
        ECHO: begin
          if (in_fire) begin
            echo_data  <= bus.s_axis_tdata_i;
            echo_valid <= 1'b1;
            remaining  <= remaining - 16'd1;
          end else if (out_fire) begin
            echo_valid <= 1'b0;
          end
        end
        ACCUM: if (in_fire) begin
          remaining <= remaining - 16'd1;
          if (op_done) begin
            acc       <= acc_next;
            res_shift <= acc_next;
            op_buf    <= '0;
            byte_pos  <= '0;
`ifdef ALU_PKT_SUB_EN
            first_op  <= 1'b0;
`endif
          end else begin
            op_buf   <= new_op;
            byte_pos <= byte_pos + 4'd1;
          end
        end
        RESULT: if (out_fire) begin
          res_shift <= res_shift >> 8;
          res_cnt   <= res_cnt - 4'd1;
        end
        DRAIN: if (in_fire) remaining <= remaining - 16'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_packet_engine.sv
// Scoreboard bench for alu_packet_engine (OPERAND_WIDTH=32, MAX_PAYLOAD=1024).
// Honours ALU_PKT_SUB_EN when deciding what opcode 0x02 should produce.
module tb_alu_packet_engine;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic busy, err;

  alu_packet_engine_if bus();

  alu_packet_engine #(.OPERAND_WIDTH(32), .MAX_PAYLOAD(1024)) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus),
    .busy_o (busy),
    .err_o  (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int err_count = 0;
  int err_exp = 0;
  int rd_mode = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Sink readiness: 0 = always ready, 1 = toggling, 2 = held off.
  always @(posedge clk) begin
    #1;
    case (rd_mode)
      0:       bus.m_axis_tready_i = 1'b1;
      1:       bus.m_axis_tready_i = (bus.m_axis_tready_i === 1'b1) ? 1'b0 : 1'b1;
      default: bus.m_axis_tready_i = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every output handshake and watches hold-while-stalled.
  always @(negedge clk) begin
    if (reset_i) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", {63'd0, bus.m_axis_tvalid_o}, 64'd1);
        check("hold_data", {56'd0, bus.m_axis_tdata_o}, {56'd0, prev_data});
      end
      if (bus.m_axis_tvalid_o === 1'b1 && bus.m_axis_tready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_out: got byte %0h expected no output", bus.m_axis_tdata_o);
        end else begin
          check("out_byte", {56'd0, bus.m_axis_tdata_o}, {56'd0, exp_q.pop_front()});
        end
      end
      stall_prev = (bus.m_axis_tvalid_o === 1'b1) && (bus.m_axis_tready_i !== 1'b1);
      prev_data  = bus.m_axis_tdata_o;
      if (err === 1'b1) err_count++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    bit   ok;
    ok = 1'b0;
    bus.s_axis_tdata_i  = b;
    bus.s_axis_tvalid_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rdy = bus.s_axis_tready_o;
      @(posedge clk);
      if (rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    #1 bus.s_axis_tvalid_i = 1'b0;
    if (!ok) begin
      checks++;
      $display("[TB] FAIL send_timeout: byte %0h not accepted, required within 64 cycles", b);
    end
  endtask

  task automatic send_tx();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  // Returns on the posedge where the scoreboard first reads empty.
  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      $display("[TB] FAIL %s_drain: got %0d pending bytes, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.s_axis_tvalid_i = 1'b0;
    bus.s_axis_tdata_i  = 8'h00;

    @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", {63'd0, bus.s_axis_tready_o}, 64'd0);
    @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_m_tvalid", {63'd0, bus.m_axis_tvalid_o}, 64'd0);
    check("rst_m_tdata", {56'd0, bus.m_axis_tdata_o}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("idle_s_tready", {63'd0, bus.s_axis_tready_o}, 64'd1);
    @(posedge clk);
    #1;

    // 5 + 7 = 12
    expect_word(32'h0000000C);
    tx_q = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    send_tx();
    wait_drain("add12"); #1;

    // FFFFFFFF + 2 wraps to 1
    expect_word(32'h00000001);
    tx_q = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    send_tx();
    wait_drain("add_wrap"); #1;

    // Three-byte partial operand zero-extended
    expect_word(32'h00030201);
    tx_q = '{8'h01, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
    send_tx();
    wait_drain("partial"); #1;

    // Empty add payload yields zero
    expect_word(32'h00000000);
    tx_q = '{8'h01, 8'h00, 8'h04, 8'h00};
    send_tx();
    wait_drain("add_empty"); #1;

    // Echo with toggling sink readiness
    rd_mode = 1;
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC); exp_q.push_back(8'hDD);
    tx_q = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_tx();
    wait_drain("echo"); #1;
    rd_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Unknown opcode drained silently, then a normal add
    err_exp++;
    tx_q = '{8'h7F, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_tx();
    expect_word(32'h00000009);
    tx_q = '{8'h01, 8'h00, 8'h08, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00};
    send_tx();
    wait_drain("after_unknown"); #1;
    @(negedge clk);
    check("err_unknown", err_count, err_exp);
    @(posedge clk); #1;

    // Opcode 0x02: 10 - 3 = 7 when enabled, otherwise rejected and drained
`ifdef ALU_PKT_SUB_EN
    expect_word(32'h00000007);
`else
    err_exp++;
`endif
    tx_q = '{8'h02, 8'h00, 8'h0C, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    send_tx();
    wait_drain("sub"); #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("err_sub", err_count, err_exp);
    @(posedge clk); #1;

    // Length below header size, then one payload byte over the limit
    err_exp++;
    tx_q = '{8'h01, 8'h00, 8'h02, 8'h00};
    send_tx();
    err_exp++;
    tx_q = '{8'h01, 8'h00, 8'h05, 8'h04};
    send_tx();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("err_len", err_count, err_exp);
    check("len_err_idle", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;

    // Maximum payload: 256 operands of 0x01010101 sum to 0x01010100 mod 2^32
    expect_word(32'h01010100);
    tx_q = '{8'h01, 8'h00, 8'h04, 8'h04};
    send_tx();
    for (int i = 0; i < 1024; i++) send_byte(8'h01);
    wait_drain("max_payload"); #1;

    // Reset after the second of four result bytes
    exp_q.push_back(8'h05); exp_q.push_back(8'h00);
    tx_q = '{8'h01, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_tx();
    wait_drain("pre_reset");
    rd_mode = 2;
    #1 reset_i = 1'b1;
    @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check("rst_mid_tvalid", {63'd0, bus.m_axis_tvalid_o}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    rd_mode = 0;
    repeat (4) @(posedge clk);
    #1;

    expect_word(32'h00004321);
    tx_q = '{8'h01, 8'h00, 8'h08, 8'h00, 8'h21, 8'h43, 8'h00, 8'h00};
    send_tx();
    wait_drain("post_reset"); #1;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("err_total", err_count, err_exp);
    check("final_idle", {63'd0, busy}, 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/alu_packet_engine.md
ALU_PACKET_ENGINE -- requirements
Module: alu_packet_engine

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 32, operand/result width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 1024, largest accepted payload in bytes (length field minus 4).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_axis_tdata_i  input  8  inbound byte (from UART RX).
REQ-006 SHALL have ports s_axis_tvalid_i input 1 / s_axis_tready_o output 1  inbound handshake; transfer when both high.
REQ-007 SHALL have port m_axis_tdata_o  output  8  outbound byte (to UART TX).
REQ-008 SHALL have ports m_axis_tvalid_o output 1 / m_axis_tready_i input 1  outbound handshake.
REQ-009 SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port err_o  output  1  one-cycle pulse on a rejected packet.

Function
REQ-011 Packet format SHALL be: opcode, reserved byte (ignored), length LSB, length MSB, payload; length counts header plus payload.
REQ-012 FSM states SHALL be IDLE, RSVD, LEN_LO, LEN_HI, ECHO, ACCUM, RESULT, DRAIN; one inbound byte per transfer advances IDLE->RSVD->LEN_LO->LEN_HI.
REQ-013 On LEN_HI accept: length<4 or length-4>MAX_PAYLOAD SHALL pulse err_o and go to IDLE (payload bytes then parsed as new header); unknown opcode SHALL pulse err_o and go to DRAIN; length==4 with add SHALL go directly to RESULT; length==4 with echo SHALL go to IDLE.
REQ-014 Opcode 0xEC (echo): each payload byte SHALL appear on m_axis with 1-cycle latency from its acceptance; s_axis_tready_o in ECHO SHALL be high only when the output register is empty or being drained that cycle (no byte loss, no duplication).
REQ-015 Opcode 0x01 (add): payload SHALL be read as little-endian OPERAND_WIDTH/8-byte operands summed modulo 2^OPERAND_WIDTH; s_axis_tready_o SHALL be high throughout ACCUM.
REQ-016 A trailing partial operand SHALL be zero-extended in its upper bytes and included in the sum.
REQ-017 RESULT SHALL emit OPERAND_WIDTH/8 bytes LSB first, starting the cycle after the last payload byte is accepted; s_axis_tready_o SHALL be low in RESULT; return to IDLE after final byte handshake.
REQ-018 m_axis_tdata_o/m_axis_tvalid_o SHALL hold stable while tvalid high and tready low.
REQ-019 DRAIN SHALL accept and discard exactly length-4 bytes with tready high, then return to IDLE; no output.
REQ-020 Payload byte counter SHALL be 16 bits; state transitions SHALL not depend on wrap-around.
REQ-021 In IDLE, RSVD, LEN_LO, LEN_HI s_axis_tready_o SHALL be high and m_axis_tvalid_o low.

Reset
REQ-022 reset_i high at a clock edge SHALL force IDLE, accumulator and counters to 0, s_axis_tready_o 0 during reset then 1 in IDLE, m_axis_tvalid_o 0, m_axis_tdata_o 0, busy_o 0, err_o 0.
REQ-023 Reset mid-packet or mid-RESULT SHALL abandon the packet; remaining result bytes SHALL never be emitted.

Configuration
REQ-024 With ALU_PKT_SUB_EN defined, opcode 0x02 SHALL be supported: result = first operand minus all later operands, modulo 2^OPERAND_WIDTH, otherwise as add (length==4 yields 0).
REQ-025 Without ALU_PKT_SUB_EN, opcode 0x02 SHALL be treated as unknown (err_o pulse, DRAIN).

Verification
REQ-026 Add, W=32: 01 00 0C 00 + 05000000,07000000 (LE) -> bytes 0C 00 00 00.
REQ-027 Add wrap, W=32: operands FFFFFFFF and 00000002 -> 01 00 00 00; partial operand: len=7, payload 01 02 03 -> 01 02 03 00.
REQ-028 Echo with backpressure: EC 00 08 00 AA BB CC DD, m_axis_tready_i toggling 1/0 -> exactly AA BB CC DD in order, tdata stable while stalled.
REQ-029 Unknown opcode 0x7F, len 8, 4 payload bytes, then valid add packet -> single err_o pulse, no output for 0x7F, correct add result after.
REQ-030 reset_i asserted after second of four result bytes -> m_axis_tvalid_o 0 next cycle, busy_o 0, no further bytes; next packet processed normally.
REQ-031 ALU_PKT_SUB_EN, W=16: 02 00 0A 00 + 0A00 0300 0200 (LE 10,3,2) -> 05 00; without macro -> err_o pulse, no output.
